// File: rtl/lane_word_aligner.sv
// Per-lane byte aligner: hunts for the training byte across all 8 bit offsets of a
// deserialized lane, locks onto one offset and streams the aligned bytes out.
module lane_word_aligner #(
    parameter logic [7:0] ALIGN_PATTERN = 8'hAC,
    parameter int         LOCK_COUNT    = 4,
    parameter int         UNLOCK_COUNT  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_data,
    input  logic       train,
    input  logic       realign,
    output logic [7:0] M_AXIS_TDATA,
    output logic       M_AXIS_TVALID,
    input  logic       M_AXIS_TREADY,
    output logic       locked,
    output logic [2:0] bit_offset,
    output logic       overflow
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] LOCK_CNT   = 5'(LOCK_COUNT);
    localparam logic [8:0] UNLOCK_CNT = 9'(UNLOCK_COUNT);

    state_t     state_q, state_d;
    logic [7:0] prev_raw_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic [2:0] off_q, off_d;
    logic [7:0] tdata_q;
    logic       tvalid_q;
    logic       locked_q;
    logic       ovf_q;

    logic [15:0] win;
    logic [7:0]  aligned;
    logic        match;
    logic [4:0]  cnt_inc;
    logic [8:0]  err_inc;

    assign win     = {raw_data, prev_raw_q};
    assign aligned = win[off_q +: 8];
    assign match   = (aligned == ALIGN_PATTERN);
    assign cnt_inc = {1'b0, cnt_q} + 5'd1;
    assign err_inc = {1'b0, err_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        off_d   = off_q;
        if (realign) begin
            state_d = SEARCH;
            cnt_d   = '0;
            err_d   = '0;
            off_d   = off_q + 3'd1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (train) begin
                        if (match) begin
                            if (LOCK_CNT == 5'd1) begin
                                state_d = LOCKED;
                                cnt_d   = '0;
                                err_d   = '0;
                            end else begin
                                state_d = VERIFY;
                                cnt_d   = 4'd1;
                            end
                        end else begin
                            off_d = off_q + 3'd1;
                        end
                    end
                end
                VERIFY: begin
                    // Losing training mid-verify restarts the hunt at the same offset.
                    if (!train) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else if (match) begin
                        if (cnt_inc == LOCK_CNT) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                            err_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[3:0];
                        end
                    end else begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                        off_d   = off_q + 3'd1;
                    end
                end
                LOCKED: begin
                    if (train) begin
                        if (match) begin
                            err_d = '0;
                        end else if (err_inc == UNLOCK_CNT) begin
                            state_d = SEARCH;
                            err_d   = '0;
                            off_d   = off_q + 3'd1;
                        end else begin
                            err_d = err_inc[7:0];
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                    err_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            prev_raw_q <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            off_q      <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            locked_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_raw_q <= raw_data;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            off_q      <= off_d;
            tdata_q    <= aligned;
            // Qualify with next state so TVALID lines up with the TDATA registered this edge.
            tvalid_q   <= (state_d == LOCKED) && !train && !realign;
            locked_q   <= (state_d == LOCKED);
            if (realign) begin
                ovf_q <= 1'b0;
            end else if (tvalid_q && !M_AXIS_TREADY) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign locked        = locked_q;
    assign bit_offset    = off_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_lane_word_aligner.sv
// Self-checking bench for lane_word_aligner: directed scenarios plus randomized traffic
// compared against a behavioural model of the alignment rules.
module tb_lane_word_aligner;

    localparam logic [7:0] PAT      = 8'hAC;
    localparam int         LOCK_N   = 4;
    localparam int         UNLOCK_N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] raw_data;
    logic       train;
    logic       realign;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       locked;
    logic [2:0] bit_offset;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: mode 0=hunting, 1=confirming, 2=locked
    int         m_mode, m_off, m_hits, m_misses;
    logic [7:0] m_prev, m_tdata;
    logic       m_tvalid, m_locked, m_ovf;

    lane_word_aligner dut (
        .clk           (clk),
        .reset         (reset),
        .raw_data      (raw_data),
        .train         (train),
        .realign       (realign),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .locked        (locked),
        .bit_offset    (bit_offset),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] view(input logic [7:0] cur, input logic [7:0] prev, input int off);
        logic [15:0] w;
        w = {cur, prev};
        w = w >> off;
        return w[7:0];
    endfunction

    function automatic logic [13:0] act_vec();
        return {tdata, tvalid, locked, bit_offset, overflow};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_tdata, m_tvalid, m_locked, 3'(m_off), m_ovf};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_hits = 0; m_misses = 0;
        m_prev = 8'h00; m_tdata = 8'h00;
        m_tvalid = 1'b0; m_locked = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] a;
        bit         hit;
        int         nm, noff, nh, nmiss;
        a     = view(raw_data, m_prev, m_off);
        hit   = (a == PAT);
        nm    = m_mode; noff = m_off; nh = m_hits; nmiss = m_misses;
        if (realign) begin
            nm = 0; noff = (m_off + 1) % 8; nh = 0; nmiss = 0;
        end else if (train) begin
            if (m_mode == 0) begin
                if (hit) begin
                    nh = 1;
                    nm = (nh >= LOCK_N) ? 2 : 1;
                end else begin
                    noff = (m_off + 1) % 8;
                end
            end else if (m_mode == 1) begin
                if (hit) begin
                    nh = m_hits + 1;
                    if (nh >= LOCK_N) nm = 2;
                end else begin
                    nm = 0; nh = 0; noff = (m_off + 1) % 8;
                end
            end else begin
                if (hit) nmiss = 0;
                else begin
                    nmiss = m_misses + 1;
                    if (nmiss >= UNLOCK_N) begin
                        nm = 0; nmiss = 0; noff = (m_off + 1) % 8;
                    end
                end
            end
        end else if (m_mode == 1) begin
            nm = 0; nh = 0;
        end
        if (nm == 2) nh = 0;
        if (realign) m_ovf = 1'b0;
        else if (m_tvalid && !tready) m_ovf = 1'b1;
        m_tdata  = a;
        m_tvalid = (nm == 2) && !train && !realign;
        m_locked = (nm == 2);
        m_prev   = raw_data;
        m_mode = nm; m_off = noff; m_hits = nh; m_misses = nmiss;
    endtask

    task automatic cyc(input logic [7:0] r, input logic t, input logic ra, input logic rdy);
        raw_data = r; train = t; realign = ra; tready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        raw_data = 8'h00; train = 1'b0; realign = 1'b0; tready = 1'b1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (act_vec() !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), 14'h0);
        end
    endtask

    task automatic test_search_lock();
        logic [2:0] eo [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(8'h65, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL search_model cyc %0d: got %h expected %h", i + 1, act_vec(), exp_vec());
            end
            n_checks++;
            if ({locked, bit_offset, tvalid} !== {(i == 6), eo[i], 1'b0}) begin
                n_fail++;
                $display("FAIL search_timing cyc %0d: got lock/off/valid %b/%0d/%b expected %b/%0d/0",
                         i + 1, locked, bit_offset, tvalid, (i == 6), eo[i]);
            end
        end
    endtask

    task automatic test_data_path();
        cyc(8'h65, 1'b0, 1'b0, 1'b1);
        cyc(8'h65, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({tvalid, tdata} !== {1'b1, 8'hAC}) begin
            n_fail++;
            $display("FAIL data_ac: got valid/data %b/%h expected 1/ac", tvalid, tdata);
        end
        cyc(8'h3C, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL data_transition: got %h expected %h", act_vec(), exp_vec());
        end
        cyc(8'h3C, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({tvalid, tdata} !== {1'b1, 8'h87}) begin
            n_fail++;
            $display("FAIL data_87: got valid/data %b/%h expected 1/87", tvalid, tdata);
        end
    endtask

    task automatic test_unlock();
        apply_reset();
        for (int i = 0; i < 7; i++) cyc(8'h65, 1'b1, 1'b0, 1'b1);
        // six bad raw bytes plus the mixed window on return make seven misses, then a clean hit
        for (int i = 0; i < 6; i++) cyc(8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h65, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({locked, bit_offset} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL unlock_tolerate: got lock/off %b/%0d expected 1/3", locked, bit_offset);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(8'h00, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL unlock_model cyc %0d: got %h expected %h", i + 1, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({locked, bit_offset} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL unlock_drop: got lock/off %b/%0d expected 0/4", locked, bit_offset);
        end
    endtask

    task automatic test_verify_fail();
        apply_reset();
        for (int i = 0; i < 5; i++) cyc(8'h65, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({locked, bit_offset} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL verify_reject: got lock/off %b/%0d expected 0/4", locked, bit_offset);
        end
        for (int i = 0; i < 30; i++) begin
            cyc(8'h65, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL verify_model cyc %0d: got %h expected %h", i + 1, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({locked, bit_offset} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL verify_relock: got lock/off %b/%0d expected 1/3", locked, bit_offset);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 7; i++) cyc(8'h65, 1'b1, 1'b0, 1'b1);
        cyc(8'h65, 1'b0, 1'b0, 1'b1);
        cyc(8'h65, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        cyc(8'h65, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
        cyc(8'h65, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({overflow, locked, tvalid, bit_offset} !== {3'b000, 3'd4}) begin
            n_fail++;
            $display("FAIL realign_clear: got ovf/lock/valid/off %b/%b/%b/%0d expected 0/0/0/4",
                     overflow, locked, tvalid, bit_offset);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 7; i++) cyc(8'h65, 1'b1, 1'b0, 1'b1);
        cyc(8'h65, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (act_vec() !== 14'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), 14'h0);
        end
        model_reset();
        #1 reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(8'h65, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if ({locked, act_vec()} !== {(i == 6), exp_vec()}) begin
                n_fail++;
                $display("FAIL async_relock cyc %0d: got lock %b vec %h expected lock %b vec %h",
                         i + 1, locked, act_vec(), (i == 6), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic t;
        t = 1'b1;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            if ($urandom_range(0, 19) == 0) t = ~t;
            r = ($urandom_range(0, 3) != 0) ? 8'h65 : 8'($urandom);
            cyc(r, t, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0));
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; raw_data = 8'h00; train = 1'b0; realign = 1'b0; tready = 1'b1;
        model_reset();
        test_reset();
        test_search_lock();
        test_data_path();
        test_unlock();
        test_verify_fail();
        test_overflow();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
